// File: rtl/mcp_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mcp_sequencer_if
// Purpose  : Handshake, configuration and enable bundle of the sequencer.
// Revision : 1.0
// ============================================================================
interface mcp_sequencer_if #(
    parameter int DIV_W = 4
);
    logic [DIV_W-1:0] cfg_ratio;
    logic             cfg_load;
    logic             in_valid;
    logic             in_ready;
    logic             shift_en;
    logic             synch_en;
    logic             dec_en;
    logic             mul_en;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [DIV_W-1:0] phase;

    modport master (
        output cfg_ratio, cfg_load, in_valid, out_ready,
        input  in_ready, shift_en, synch_en, dec_en, mul_en, out_valid, busy, phase
    );

    modport slave (
        input  cfg_ratio, cfg_load, in_valid, out_ready,
        output in_ready, shift_en, synch_en, dec_en, mul_en, out_valid, busy, phase
    );
endinterface
`default_nettype wire

// File: rtl/mcp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mcp_sequencer
// Purpose  : Issues capture enables for a two-stage multicycle datapath.
// Revision : 1.0
// ============================================================================
module mcp_sequencer #(
    parameter int DIV_W       = 4,
    parameter int RESET_RATIO = 4
) (
    input  wire logic           fast_clk,
    input  wire logic           reset,
    mcp_sequencer_if.slave      bus
);
    localparam logic [DIV_W-1:0] C_RESET_RATIO = DIV_W'(RESET_RATIO);
    localparam logic [DIV_W-1:0] C_MIN_RATIO   = DIV_W'(2);
    localparam logic [DIV_W-1:0] C_ONE         = DIV_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_S1   = 3'd2,
        ST_S2   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_phase;
    logic [DIV_W-1:0] w_phase_nxt;
    logic [DIV_W-1:0] r_ratio;
    logic [DIV_W-1:0] r_txn_ratio;
    logic [DIV_W-1:0] r_pend_ratio;
    logic             r_pend_valid;

    logic             w_accept;
    logic             w_last;
    logic             w_enter_idle;
    logic [DIV_W-1:0] w_cfg_clamped;
    logic             w_in_ready;
    logic             w_shift_en;
    logic             w_synch_en;
    logic             w_dec_en;
    logic             w_mul_en;
    logic             w_out_valid;

    assign w_cfg_clamped = (bus.cfg_ratio < C_MIN_RATIO) ? C_MIN_RATIO : bus.cfg_ratio;
    assign w_accept      = bus.in_valid & w_in_ready;
    assign w_last        = (r_phase == (r_txn_ratio - C_ONE));
    assign w_enter_idle  = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = '0;
        w_in_ready  = 1'b0;
        w_shift_en  = 1'b0;
        w_synch_en  = 1'b0;
        w_dec_en    = 1'b0;
        w_mul_en    = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = ~reset;
                w_shift_en = bus.in_valid & ~reset;
                if (bus.in_valid) begin
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                w_synch_en  = 1'b1;
                w_state_nxt = ST_S1;
            end
            ST_S1: begin
                if (w_last) begin
                    w_dec_en    = 1'b1;
                    w_state_nxt = ST_S2;
                end else begin
                    w_phase_nxt = r_phase + C_ONE;
                end
            end
            ST_S2: begin
                if (w_last) begin
                    w_mul_en    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_phase_nxt = r_phase + C_ONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset masks every output in the same cycle, so an abort emits nothing.
    assign bus.in_ready  = w_in_ready;
    assign bus.shift_en  = w_shift_en;
    assign bus.synch_en  = w_synch_en & ~reset;
    assign bus.dec_en    = w_dec_en & ~reset;
    assign bus.mul_en    = w_mul_en & ~reset;
    assign bus.out_valid = w_out_valid & ~reset;
    assign bus.busy      = (r_state != ST_IDLE) & ~reset;
    assign bus.phase     = reset ? '0 : r_phase;

    always_ff @(posedge fast_clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_phase      <= '0;
            r_ratio      <= C_RESET_RATIO;
            r_txn_ratio  <= C_RESET_RATIO;
            r_pend_ratio <= C_RESET_RATIO;
            r_pend_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            if (w_accept) begin
                r_txn_ratio <= r_ratio;
            end
            // Ratio only changes while idle or on the edge returning to idle.
            if (r_state == ST_IDLE) begin
                if (bus.cfg_load) begin
                    r_ratio <= w_cfg_clamped;
                end
            end else if (w_enter_idle) begin
                if (bus.cfg_load) begin
                    r_ratio <= w_cfg_clamped;
                end else if (r_pend_valid) begin
                    r_ratio <= r_pend_ratio;
                end
                r_pend_valid <= 1'b0;
            end else if (bus.cfg_load) begin
                r_pend_ratio <= w_cfg_clamped;
                r_pend_valid <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mcp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcp_sequencer
// Purpose  : Directed bench with a timeline-based reference model.
// Revision : 1.0
// ============================================================================
module tb_mcp_sequencer;
    localparam int DIV_W       = 4;
    localparam int RESET_RATIO = 4;

    logic clk;
    logic rst;

    mcp_sequencer_if #(.DIV_W(DIV_W)) bus ();

    mcp_sequencer #(
        .DIV_W       (DIV_W),
        .RESET_RATIO (RESET_RATIO)
    ) dut (
        .fast_clk (clk),
        .reset    (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int ev_shift, ev_synch, ev_dec, ev_mul, ev_ov, ov_cnt;

    // Model: a transaction is a timeline relative to its accept cycle.
    int cyc    = 0;
    bit m_txn  = 1'b0;
    int m_t0   = 0;
    int m_R    = RESET_RATIO;
    int m_act  = RESET_RATIO;
    int m_pend = 0;
    bit m_pv   = 1'b0;

    function automatic int clamp(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    always @(negedge clk) begin : mon
        logic [10:0] exp_v;
        logic [10:0] act_v;
        logic        e_ir, e_sh, e_sy, e_de, e_mu, e_ov, e_bz;
        int          e_ph;
        int          k;
        e_ir = 0; e_sh = 0; e_sy = 0; e_de = 0; e_mu = 0; e_ov = 0; e_bz = 0;
        e_ph = 0;
        k = cyc - m_t0;
        if (!rst) begin
            if (!m_txn) begin
                e_ir = 1'b1;
                e_sh = bus.in_valid;
            end else begin
                e_bz = 1'b1;
                if (k == 1) begin
                    e_sy = 1'b1;
                end else if (k <= m_R + 1) begin
                    e_ph = k - 2;
                    e_de = (k == m_R + 1);
                end else if (k <= 2 * m_R + 1) begin
                    e_ph = k - m_R - 2;
                    e_mu = (k == 2 * m_R + 1);
                end else begin
                    e_ov = 1'b1;
                end
            end
        end
        exp_v = {e_ir, e_sh, e_sy, e_de, e_mu, e_ov, e_bz, 4'(e_ph)};
        act_v = {bus.in_ready, bus.shift_en, bus.synch_en, bus.dec_en, bus.mul_en,
                 bus.out_valid, bus.busy, bus.phase};
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL outputs cycle %0d: got %b want %b (ir sh sy de mu ov bz phase)",
                     cyc, act_v, exp_v);
        end

        if (bus.shift_en  && ev_shift < 0) ev_shift = cyc;
        if (bus.synch_en  && ev_synch < 0) ev_synch = cyc;
        if (bus.dec_en    && ev_dec   < 0) ev_dec   = cyc;
        if (bus.mul_en    && ev_mul   < 0) ev_mul   = cyc;
        if (bus.out_valid && ev_ov    < 0) ev_ov    = cyc;
        if (bus.out_valid) ov_cnt++;

        if (rst) begin
            m_txn = 1'b0;
            m_act = RESET_RATIO;
            m_pv  = 1'b0;
        end else if (!m_txn) begin
            if (bus.in_valid) begin
                m_txn = 1'b1;
                m_t0  = cyc;
                m_R   = m_act;
            end
            if (bus.cfg_load) m_act = clamp(int'(bus.cfg_ratio));
        end else begin
            if (bus.cfg_load) begin
                m_pend = clamp(int'(bus.cfg_ratio));
                m_pv   = 1'b1;
            end
            if (k >= 2 * m_R + 2 && bus.out_ready) begin
                m_txn = 1'b0;
                if (m_pv) begin
                    m_act = m_pend;
                    m_pv  = 1'b0;
                end
            end
        end
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_ev();
        ev_shift = -1; ev_synch = -1; ev_dec = -1; ev_mul = -1; ev_ov = -1;
        ov_cnt = 0;
    endtask

    task automatic accept_once();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic load_ratio(input int v);
        bus.cfg_ratio = 4'(v);
        bus.cfg_load  = 1'b1;
        tick();
        bus.cfg_load  = 1'b0;
    endtask

    initial begin
        clr_ev();
        rst           = 1'b1;
        bus.cfg_ratio = '0;
        bus.cfg_load  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(3);
        chk("reset_in_ready", int'(bus.in_ready), 0);
        chk("reset_busy", int'(bus.busy), 0);
        rst = 1'b0;
        tick();
        chk("post_reset_in_ready", int'(bus.in_ready), 1);

        // Basic R=4 transaction
        clr_ev();
        accept_once();
        idle(11);
        chk("r4_synch", ev_synch - ev_shift, 1);
        chk("r4_dec", ev_dec - ev_shift, 5);
        chk("r4_mul", ev_mul - ev_shift, 9);
        chk("r4_out_valid", ev_ov - ev_shift, 10);
        chk("r4_ov_cycles", ov_cnt, 1);

        // Backpressure: 7 cycles of out_ready low in DONE
        bus.out_ready = 1'b0;
        clr_ev();
        accept_once();
        idle(16);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_ov_cycles", ov_cnt, 8);
        chk("bp_out_valid", ev_ov - ev_shift, 10);
        chk("bp_back_idle", int'(bus.in_ready), 1);

        // Ratio 0 clamps to 2; in_valid held high is ignored while busy
        load_ratio(0);
        clr_ev();
        bus.in_valid = 1'b1;
        idle(6);
        bus.in_valid = 1'b0;
        idle(2);
        chk("r2_dec", ev_dec - ev_shift, 3);
        chk("r2_mul", ev_mul - ev_shift, 5);
        chk("r2_out_valid", ev_ov - ev_shift, 6);

        // Loads during S1 are deferred; last one wins
        load_ratio(4);
        clr_ev();
        accept_once();
        tick();
        bus.cfg_ratio = 4'd7;
        bus.cfg_load  = 1'b1;
        tick();
        bus.cfg_ratio = 4'd9;
        tick();
        bus.cfg_load  = 1'b0;
        idle(7);
        chk("defer_dec", ev_dec - ev_shift, 5);
        chk("defer_out_valid", ev_ov - ev_shift, 10);
        clr_ev();
        accept_once();
        idle(21);
        chk("r9_mul", ev_mul - ev_shift, 19);
        chk("r9_out_valid", ev_ov - ev_shift, 20);

        // Reset at S2 phase 2 of an R=9 transaction
        clr_ev();
        accept_once();
        idle(12);
        chk("abort_phase", int'(bus.phase), 2);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_in_ready", int'(bus.in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_ready_after", int'(bus.in_ready), 1);
        idle(20);
        chk("abort_no_mul", ev_mul, -1);
        chk("abort_no_ov", ev_ov, -1);
        clr_ev();
        accept_once();
        idle(11);
        chk("after_abort_out_valid", ev_ov - ev_shift, 10);

        // Load coincident with accept applies from the next transaction
        clr_ev();
        bus.cfg_ratio = 4'd15;
        bus.cfg_load  = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        bus.cfg_load  = 1'b0;
        bus.in_valid  = 1'b0;
        idle(11);
        chk("same_cycle_out_valid", ev_ov - ev_shift, 10);
        clr_ev();
        accept_once();
        idle(33);
        chk("r15_out_valid", ev_ov - ev_shift, 32);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
